// File: rtl/priority_req_serializer_if.sv
// Handshake bundle for the request serializer: request-word load channel
// and index beat channel.
interface priority_req_serializer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_vec;
  logic             idx_valid;
  logic             idx_ready;
  logic [IDX_W-1:0] idx_out;

  modport master (
    output load_valid, load_vec, idx_ready,
    input  load_ready, idx_valid, idx_out
  );

  modport slave (
    input  load_valid, load_vec, idx_ready,
    output load_ready, idx_valid, idx_out
  );
endinterface

// File: rtl/priority_req_serializer.sv
// Captures a request word and emits its set-bit indices, highest first,
// one per handshake beat; an all-zero word yields a single 8'hF0 beat.
module priority_req_serializer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  priority_req_serializer_if.slave     bus,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   count
);
  localparam int unsigned SEL_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH+1);
  localparam logic [IDX_W-1:0] NONE_CODE = 8'hF0;

  typedef enum logic [1:0] {IDLE, EMIT, ZERO} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] clr_mask;
  logic             load_fire;
  logic             idx_fire;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    idx      = '0;
    clr_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (pending_q[i]) idx = i[SEL_W-1:0];
    end
    clr_mask[idx] = 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    count_d        = count_q;
    bus.load_ready = 1'b0;
    bus.idx_valid  = 1'b0;
    bus.idx_out    = NONE_CODE;
    load_fire      = 1'b0;
    idx_fire       = 1'b0;

    case (state_q)
      IDLE: begin
        // rst_n gating keeps load_ready low while reset is held.
        bus.load_ready = ena & rst_n;
        load_fire      = bus.load_valid & bus.load_ready;
        if (load_fire) begin
          pending_d = bus.load_vec;
          count_d   = '0;
          state_d   = (bus.load_vec == '0) ? ZERO : EMIT;
        end
      end
      EMIT: begin
        bus.idx_valid = ena;
        if (ena) bus.idx_out = {{(IDX_W-SEL_W){1'b0}}, idx};
        idx_fire = bus.idx_valid & bus.idx_ready;
        if (idx_fire) begin
          pending_d = pending_q & ~clr_mask;
          count_d   = count_q + 1'b1;
          if (pending_d == '0) state_d = IDLE;
        end
      end
      ZERO: begin
        bus.idx_valid = ena;
        idx_fire      = bus.idx_valid & bus.idx_ready;
        if (idx_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
    end else if (ena) begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign count = count_q;
endmodule

// File: tb/tb_priority_req_serializer.sv
// Directed bench for priority_req_serializer: table of per-cycle vectors
// followed by hand-written ena-freeze and mid-stream reset sequences.
module tb_priority_req_serializer;
  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       busy;
  logic [4:0] count;
  int         checks;
  int         errors;

  priority_req_serializer_if #(.WIDTH(16), .IDX_W(8)) bif ();

  priority_req_serializer #(.WIDTH(16), .IDX_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bif.slave),
    .busy  (busy),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic [15:0] vec;
    logic        rdy;
    logic        en;
    logic        vld;
    logic        lrdy;
    logic [7:0]  idx;
    logic [4:0]  cnt;
    logic        bsy;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic vld, input logic lrdy,
                            input logic [7:0] idx, input logic [4:0] cnt, input logic bsy);
    chk({tag, ".idx_valid"},  {31'b0, bif.idx_valid},  {31'b0, vld});
    chk({tag, ".load_ready"}, {31'b0, bif.load_ready}, {31'b0, lrdy});
    chk({tag, ".idx_out"},    {24'b0, bif.idx_out},    {24'b0, idx});
    chk({tag, ".count"},      {27'b0, count},          {27'b0, cnt});
    chk({tag, ".busy"},       {31'b0, busy},           {31'b0, bsy});
  endtask

  // Drive one handshake beat with ready high and check it at mid-cycle.
  task automatic beat(input string tag, input logic [7:0] idx, input logic [4:0] cnt);
    bif.load_valid = 1'b0;
    bif.idx_ready  = 1'b1;
    #1;
    check_outs(tag, 1'b1, 1'b0, idx, cnt, 1'b1);
    @(negedge clk);
  endtask

  task automatic load_word(input string tag, input logic [15:0] v, input logic [4:0] cnt);
    bif.load_valid = 1'b1;
    bif.load_vec   = v;
    bif.idx_ready  = 1'b1;
    #1;
    check_outs(tag, 1'b0, 1'b1, 8'hF0, cnt, 1'b0);
    @(negedge clk);
    bif.load_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    bif.load_valid = 1'b0;
    bif.load_vec   = '0;
    bif.idx_ready  = 1'b0;

    //          lv   vec       rdy  en    vld  lrdy idx    cnt   bsy
    tbl[0]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 8'hF0, 5'd0, 1'b0};
    tbl[1]  = '{1'b1, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b1, 8'hF0, 5'd0, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 8'd15,  5'd0, 1'b1};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,   5'd1, 1'b1};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 8'hF0, 5'd2, 1'b0};
    tbl[5]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 8'hF0, 5'd2, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 8'hF0, 5'd0, 1'b1};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 8'hF0, 5'd0, 1'b0};
    tbl[8]  = '{1'b1, 16'h0024, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF0, 5'd0, 1'b0};
    tbl[9]  = '{1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'd5,   5'd0, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'd5,   5'd0, 1'b1};
    tbl[11] = '{1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 8'd5,   5'd0, 1'b1};
    tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5,   5'd0, 1'b1};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2,   5'd1, 1'b1};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 8'hF0, 5'd2, 1'b0};
    tbl[15] = '{1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 5'd2, 1'b0};

    repeat (2) @(negedge clk);
    #1;
    check_outs("reset_held", 1'b0, 1'b0, 8'hF0, 5'd0, 1'b0);
    rst_n = 1'b1;
    #1;
    check_outs("reset_release", 1'b0, 1'b1, 8'hF0, 5'd0, 1'b0);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      bif.load_valid = tbl[i].lv;
      bif.load_vec   = tbl[i].vec;
      bif.idx_ready  = tbl[i].rdy;
      ena            = tbl[i].en;
      #1;
      check_outs($sformatf("row%0d", i), tbl[i].vld, tbl[i].lrdy, tbl[i].idx, tbl[i].cnt, tbl[i].bsy);
      @(negedge clk);
    end
    ena = 1'b1;
    bif.load_valid = 1'b0;

    // 16'hFFFF with ena dropped for four cycles after beat 12.
    load_word("ffff_load", 16'hFFFF, 5'd2);
    for (int b = 15; b >= 12; b--)
      beat($sformatf("ffff_b%0d", b), 8'(b), 5'(15 - b));
    ena = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_outs($sformatf("ffff_frozen%0d", c), 1'b0, 1'b0, 8'hF0, 5'd4, 1'b1);
      @(negedge clk);
    end
    ena = 1'b1;
    for (int b = 11; b >= 0; b--)
      beat($sformatf("ffff_b%0d", b), 8'(b), 5'(15 - b));
    bif.idx_ready = 1'b1;
    #1;
    check_outs("ffff_done", 1'b0, 1'b1, 8'hF0, 5'd16, 1'b0);
    @(negedge clk);

    // 16'hF00F interrupted by reset after beat 14, then a fresh 16'h0100.
    load_word("f00f_load", 16'hF00F, 5'd16);
    beat("f00f_b15", 8'd15, 5'd0);
    beat("f00f_b14", 8'd14, 5'd1);
    rst_n = 1'b0;
    #1;
    check_outs("midrst_asserted", 1'b0, 1'b0, 8'hF0, 5'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outs("midrst_released", 1'b0, 1'b1, 8'hF0, 5'd0, 1'b0);
    @(negedge clk);
    load_word("w0100_load", 16'h0100, 5'd0);
    beat("w0100_b8", 8'd8, 5'd0);
    #1;
    check_outs("w0100_done", 1'b0, 1'b1, 8'hF0, 5'd1, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
